inst_rom: RTL and testbench
===========================

# inst_rom

Synchronous instruction memory that answers fetch requests from the program-counter stage. Each cycle the PC stage drives an address and a chip enable. This block returns the addressed 32-bit instruction one clock later, with a valid flag, per-fetch fault flags, a sticky fault record and a fetch counter. A word-wide load port lets a loader or testbench fill the array, including while the core is held in reset.

## Interface

Parameters:
- ADDR_W, 32, width of instruction address bus (matches `InstAddrBus`)
- DATA_W, 32, instruction width
- DEPTH_LOG2, 10, log2 of array depth in words (default 1024 words)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (equals `CpuResetAddr`)
- NOP_INST, 32'h0000_0013, instruction returned on any faulted fetch

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; synchronous, active-high (`RstEnable`)
- pc_i  in  ADDR_W  fetch byte address from PC stage
- ce_i  in  1  fetch enable from PC stage (`ChipEnable` = 1)
- inst_o  out  DATA_W  fetched instruction
- inst_addr_o  out  ADDR_W  pc_i that produced inst_o
- inst_valid_o  out  1  inst_o/inst_addr_o carry a fetch result this cycle
- misalign_o  out  1  current result came from pc_i[1:0] != 0
- oob_o  out  1  current result came from an address outside the array
- err_sticky_o  out  1  a faulted fetch has occurred since reset
- err_addr_o  out  ADDR_W  pc_i of the first faulted fetch since reset
- fetch_cnt_o  out  32  number of valid fetches since reset, saturating
- we_i  in  1  load-port write enable
- waddr_i  in  ADDR_W  load-port byte address
- wdata_i  in  DATA_W  load-port data

## Operation

- Offset: off = pc_i - BASE_ADDR, ADDR_W-bit modulo arithmetic. Word index = off[DEPTH_LOG2+1:2].
- In range: off < 4·2^DEPTH_LOG2, unsigned. Addresses below BASE_ADDR wrap to large offsets and count as out of range.
- Misaligned: pc_i[1:0] != 2'b00. Misalignment takes precedence; when it is set, oob is still evaluated and reported independently.
- Fetch (ce_i=1, rst_i=0), registered at the next edge:
  - inst_valid_o ← 1
  - inst_addr_o ← pc_i
  - inst_o ← mem[index] if aligned and in range, else NOP_INST
  - misalign_o and oob_o ← the computed flags
- Idle (ce_i=0, rst_i=0), at the next edge:
  - inst_valid_o, misalign_o and oob_o ← 0
  - inst_o ← 0
  - inst_addr_o holds its value
- Sticky fault:
  - On the first faulted fetch (misaligned or out of range) with err_sticky_o=0: err_sticky_o ← 1 and err_addr_o ← pc_i.
  - Later faults do not change err_addr_o.
  - Only reset clears the sticky record.
- Counter: fetch_cnt_o increments by 1 on every fetch, faulted or not. It saturates at 32'hFFFF_FFFF.
- Load port:
  - When we_i=1 and waddr_i is aligned and in range (same rules as fetch), mem[index(waddr_i)] ← wdata_i.
  - Misaligned or out-of-range writes are dropped silently.
  - Writes are accepted regardless of rst_i.
- Memory is never cleared by reset; contents are undefined until written.

## Timing

- Read latency 1 cycle: request sampled at edge N, result visible after edge N (cycle N+1). One fetch per cycle at full throughput, no backpressure.
- Reset (rst_i=1 at an edge) sets inst_o=0, inst_addr_o=0, inst_valid_o=0, misalign_o=0, oob_o=0, err_sticky_o=0, err_addr_o=0 and fetch_cnt_o=0. Reset overrides any ce_i on that edge.
- Reset in the middle of a stream: the in-flight result is discarded; outputs are at reset values after that edge.
- After reset, the PC stage raises ce_i one cycle after rst_i falls, with pc_i=BASE_ADDR. The first valid result appears one cycle after that.
- Simultaneous load-port write and fetch to the same word at the same edge: the fetch returns the old contents (read-first). The new data is visible to fetches issued from the next edge onward.
- Fetch on the same edge as saturation: fetch_cnt_o stays at all-ones.

## Test plan

- Preload words 0..3 with 32'h0000_0093, 32'h0010_0113, 32'h0020_0193 and 32'h0030_0213. Release reset and drive pc_i = 0, 4, 8, 12 with ce_i=1. Required: inst_o returns those four words in order, each one cycle after its request; inst_valid_o=1; inst_addr_o matches; fetch_cnt_o = 1, 2, 3, 4.
- Fetch pc_i=32'h0000_0006. Required next cycle: inst_o=32'h0000_0013, misalign_o=1, oob_o=0, err_sticky_o=1, err_addr_o=6.
- With DEPTH_LOG2=10, fetch pc_i=32'h0000_1000, then 32'h0000_2000. Required: oob_o=1 and inst_o=NOP_INST for both; err_addr_o stays 32'h0000_1000.
- Write word 5 with 32'hDEAD_BEEF while fetching pc_i=20 on the same edge. Required: that fetch returns the old word; a fetch of pc_i=20 on the next cycle returns 32'hDEAD_BEEF.
- Assert rst_i for one cycle in the middle of a fetch stream. Required: all outputs go to their reset values after that edge and the sticky fault is cleared; memory contents are preserved; the next fetch of pc_i=0 returns the preloaded word 0.
- Drop ce_i for 2 cycles mid-stream. Required: inst_valid_o=0 and inst_o=0 for those 2 cycles; inst_addr_o and fetch_cnt_o hold their values.

Source files
------------

// File: rtl/inst_rom.sv
// Synchronous instruction ROM/RAM for the fetch stage: one-cycle read latency,
// per-fetch fault flags, sticky first-fault record and a saturating fetch counter.
module inst_rom #(
    parameter int unsigned            ADDR_W     = 32,
    parameter int unsigned            DATA_W     = 32,
    parameter int unsigned            DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0]      BASE_ADDR  = 32'h0000_0000,
    parameter logic [DATA_W-1:0]      NOP_INST   = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              misalign_o,
    output logic              oob_o,
    output logic              err_sticky_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [31:0]       fetch_cnt_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [DATA_W-1:0] inst_r;
    logic [ADDR_W-1:0] inst_addr_r;
    logic              inst_valid_r;
    logic              misalign_r;
    logic              oob_r;
    logic              err_sticky_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic [31:0]       fetch_cnt_r;

    logic                  fetch_mis_s;
    logic                  fetch_oob_s;
    logic                  fetch_fault_s;
    logic [DEPTH_LOG2-1:0] fetch_idx_s;
    logic                  write_ok_s;
    logic [DEPTH_LOG2-1:0] write_idx_s;

    // Offsets below BASE_ADDR wrap to huge values, so a single upper-bits test covers both sides.
    function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return (off[ADDR_W-1:DEPTH_LOG2+2] != '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return off[DEPTH_LOG2+1:2];
    endfunction

    // Address decode for the fetch and load ports.
    always_comb begin
        fetch_mis_s   = (pc_i[1:0] != 2'b00);
        fetch_oob_s   = addr_oob(pc_i);
        fetch_fault_s = fetch_mis_s | fetch_oob_s;
        fetch_idx_s   = addr_idx(pc_i);
        write_idx_s   = addr_idx(waddr_i);
        if (we_i) begin
            write_ok_s = (waddr_i[1:0] == 2'b00) && !addr_oob(waddr_i);
        end else begin
            write_ok_s = 1'b0;
        end
    end

    // Load port; independent of reset so the array can be filled while the core is held.
    always_ff @(posedge clk_i) begin
        if (write_ok_s) begin
            mem_r[write_idx_s] <= wdata_i;
        end
    end

    // Fetch pipeline register, fault record and counter; reads see pre-write contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inst_r       <= '0;
            inst_addr_r  <= '0;
            inst_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
            oob_r        <= 1'b0;
            err_sticky_r <= 1'b0;
            err_addr_r   <= '0;
            fetch_cnt_r  <= 32'd0;
        end else if (ce_i) begin
            inst_valid_r <= 1'b1;
            inst_addr_r  <= pc_i;
            inst_r       <= fetch_fault_s ? NOP_INST : mem_r[fetch_idx_s];
            misalign_r   <= fetch_mis_s;
            oob_r        <= fetch_oob_s;
            if (fetch_fault_s && !err_sticky_r) begin
                err_sticky_r <= 1'b1;
                err_addr_r   <= pc_i;
            end
            if (fetch_cnt_r != 32'hFFFF_FFFF) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
        end else begin
            inst_valid_r <= 1'b0;
            inst_r       <= '0;
            misalign_r   <= 1'b0;
            oob_r        <= 1'b0;
        end
    end

    assign inst_o       = inst_r;
    assign inst_addr_o  = inst_addr_r;
    assign inst_valid_o = inst_valid_r;
    assign misalign_o   = misalign_r;
    assign oob_o        = oob_r;
    assign err_sticky_o = err_sticky_r;
    assign err_addr_o   = err_addr_r;
    assign fetch_cnt_o  = fetch_cnt_r;

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: directed test-plan sequence plus random
// traffic, all compared against an array-based reference model.
module tb_inst_rom;

    localparam int DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'd0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] waddr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] inst, inst_addr, err_addr, fetch_cnt;
    logic        inst_valid, misalign, oob, err_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state (expected outputs after the last edge)
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] e_inst, e_addr, e_erraddr, e_cnt;
    logic        e_valid, e_mis, e_oob, e_sticky;

    inst_rom dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .ce_i(ce),
        .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid),
        .misalign_o(misalign), .oob_o(oob), .err_sticky_o(err_sticky),
        .err_addr_o(err_addr), .fetch_cnt_o(fetch_cnt),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Advance one clock: predict from the spec rules, then compare after the edge.
    task automatic tick();
        logic [31:0] off;
        logic [31:0] woff;
        logic        f_mis, f_oob;
        if (rst) begin
            e_inst = 32'd0; e_addr = 32'd0; e_valid = 1'b0; e_mis = 1'b0; e_oob = 1'b0;
            e_sticky = 1'b0; e_erraddr = 32'd0; e_cnt = 32'd0;
        end else if (ce) begin
            off   = pc - 32'd0;
            f_mis = (pc % 32'd4) != 32'd0;
            f_oob = off >= 32'd4 * DEPTH;
            e_valid = 1'b1; e_addr = pc; e_mis = f_mis; e_oob = f_oob;
            e_inst  = (f_mis || f_oob) ? NOP : mdl_mem[off / 32'd4];
            if ((f_mis || f_oob) && !e_sticky) begin
                e_sticky = 1'b1; e_erraddr = pc;
            end
            if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
        end else begin
            e_valid = 1'b0; e_inst = 32'd0; e_mis = 1'b0; e_oob = 1'b0;
        end
        // write after the read prediction: read-first
        woff = waddr - 32'd0;
        if (we && (waddr % 32'd4) == 32'd0 && woff < 32'd4 * DEPTH)
            mdl_mem[woff / 32'd4] = wdata;
        @(posedge clk);
        #1;
        check("inst", inst, e_inst);
        check("inst_addr", inst_addr, e_addr);
        check("valid", {31'd0, inst_valid}, {31'd0, e_valid});
        check("misalign", {31'd0, misalign}, {31'd0, e_mis});
        check("oob", {31'd0, oob}, {31'd0, e_oob});
        check("sticky", {31'd0, err_sticky}, {31'd0, e_sticky});
        check("err_addr", err_addr, e_erraddr);
        check("fetch_cnt", fetch_cnt, e_cnt);
    endtask

    task automatic fetch(input logic [31:0] a);
        ce = 1'b1; pc = a; tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) return 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        else if (sel < 8) return (32'($urandom_range(0, DEPTH - 1)) * 32'd4) | 32'($urandom_range(1, 3));
        else return 32'h0000_1000 + 32'($urandom);
    endfunction

    initial begin
        #1;
        // fill the whole array while held in reset
        rst = 1'b1; we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            waddr = 32'(i) * 32'd4; wdata = $urandom; tick();
        end
        waddr = 32'd0;  wdata = 32'h0000_0093; tick();
        waddr = 32'd4;  wdata = 32'h0010_0113; tick();
        waddr = 32'd8;  wdata = 32'h0020_0193; tick();
        waddr = 32'd12; wdata = 32'h0030_0213; tick();
        we = 1'b0;
        rst = 1'b0; ce = 1'b0; tick();

        fetch(32'd0);  check("tp_w0", inst, 32'h0000_0093);
        fetch(32'd4);  check("tp_w1", inst, 32'h0010_0113);
        fetch(32'd8);  check("tp_w2", inst, 32'h0020_0193);
        fetch(32'd12); check("tp_w3", inst, 32'h0030_0213);
        check("tp_cnt4", fetch_cnt, 32'd4);

        fetch(32'd6);
        check("tp_mis_nop", inst, NOP);
        check("tp_mis_erraddr", err_addr, 32'd6);

        rst = 1'b1; ce = 1'b0; tick();
        rst = 1'b0;
        fetch(32'h0000_1000); check("tp_oob1", {31'd0, oob}, 32'd1);
        fetch(32'h0000_2000); check("tp_oob2_nop", inst, NOP);
        check("tp_oob_erraddr", err_addr, 32'h0000_1000);

        // write and fetch word 5 on the same edge
        we = 1'b1; waddr = 32'd20; wdata = 32'hDEAD_BEEF;
        fetch(32'd20);
        we = 1'b0;
        fetch(32'd20); check("tp_rw_new", inst, 32'hDEAD_BEEF);

        // reset mid-stream
        fetch(32'd4);
        rst = 1'b1; fetch(32'd8);
        check("tp_rst_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b0;
        fetch(32'd0); check("tp_rst_mem", inst, 32'h0000_0093);

        // ce dropped for two cycles
        fetch(32'd12);
        ce = 1'b0; tick(); tick();
        check("tp_idle_addr", inst_addr, 32'd12);
        check("tp_idle_cnt", fetch_cnt, 32'd2);
        fetch(32'd4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            ce    = ($urandom_range(0, 9) < 8);
            pc    = rand_addr();
            we    = ($urandom_range(0, 9) < 3);
            waddr = ($urandom_range(0, 3) == 0) ? pc : rand_addr();
            wdata = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
